seg7_scan_capture: RTL and testbench

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

---
 rtl/seg7_scan_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
//
// Purpose:
//   Passive monitor for a multiplexed 4-digit 7-segment display.
//   - Samples the segment bus and the digit enables once per clk_1khz edge.
//   - Rebuilds the DK1..DK4 scan into a frame.
//   - Delivers each frame with a valid/ack handshake.
//   - Flags scan-order errors, overruns and a stale (no recent frame) condition.
//
// Ports:
//   clk_1khz     in   scan clock; every register samples on its rising edge
//   rst          in   asynchronous active-high reset
//   seg[6:0]     in   segment bus, gfedcba order, 1 = lit
//   an[3:0]      in   digit enable, one-hot active-high; 4'b1000 = DK1 (leftmost)
//   frame_ack    in   consumer acknowledge for frame_valid
//   dk1..dk4     out  raw segment patterns of the last delivered frame
//   code1..code4 out  decoded digits (0-9, A = blank, F = unknown pattern)
//   frame_valid  out  new frame available; held until acknowledged
//   overrun      out  sticky: a frame was delivered while frame_valid was pending
//   scan_err     out  one-cycle pulse on an illegal or out-of-order enable
//   stale        out  STALE_LIMIT or more cycles since the last completed frame
//
// Configuration:
//   SEG7_CAPTURE_CHANGE_ONLY_EN
//     - When defined, a completed frame identical to the held dk1..dk4 is not
//       delivered, but it still clears the stale counter.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module seg7_scan_capture #(
  parameter int unsigned STALE_LIMIT = 8
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  input  logic       frame_ack,
  output logic [6:0] dk1,
  output logic [6:0] dk2,
  output logic [6:0] dk3,
  output logic [6:0] dk4,
  output logic [3:0] code1,
  output logic [3:0] code2,
  output logic [3:0] code3,
  output logic [3:0] code4,
  output logic       frame_valid,
  output logic       overrun,
  output logic       scan_err,
  output logic       stale
);

  localparam int unsigned CntW = (STALE_LIMIT > 0) ? $clog2(STALE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] StaleMax = CntW'(STALE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StGot1,
    StGot2,
    StGot3
  } state_e;

  // Pattern -> digit. Blank is 4'hA so an unlit digit stays distinguishable
  // from an unrecognised pattern (4'hF).
  function automatic logic [3:0] decode_seg(input logic [6:0] p);
    logic [3:0] d;
    case (p)
      7'b0111111: d = 4'h0;
      7'b0000110: d = 4'h1;
      7'b1011011: d = 4'h2;
      7'b1001111: d = 4'h3;
      7'b1100110: d = 4'h4;
      7'b1101101: d = 4'h5;
      7'b1111101: d = 4'h6;
      7'b0000111: d = 4'h7;
      7'b1111111: d = 4'h8;
      7'b1101111: d = 4'h9;
      7'b0000000: d = 4'hA;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  state_e     r_state;
  logic [6:0] r_sh1;
  logic [6:0] r_sh2;
  logic [6:0] r_sh3;
  logic       r_scan_err;

  logic [6:0] r_dk1;
  logic [6:0] r_dk2;
  logic [6:0] r_dk3;
  logic [6:0] r_dk4;
  logic [3:0] r_code1;
  logic [3:0] r_code2;
  logic [3:0] r_code3;
  logic [3:0] r_code4;
  logic       r_frame_valid;
  logic       r_overrun;

  logic [CntW-1:0] r_stale_cnt;

  logic w_an_zero;
  logic w_an_onehot;
  logic w_complete;
  logic w_deliver;

  assign w_an_zero   = (an == 4'b0000);
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign w_an_onehot = !w_an_zero && ((an & (an - 4'd1)) == 4'b0000);
  assign w_complete  = (r_state == StGot3) && (an == 4'b0001);

`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
  logic w_same;
  assign w_same    = ({r_sh1, r_sh2, r_sh3, seg} == {r_dk1, r_dk2, r_dk3, r_dk4});
  assign w_deliver = w_complete && !w_same;
`else
  assign w_deliver = w_complete;
`endif

  // Assembly FSM. DK1 restarts a scan from any state; in idle, other digits
  // are skipped quietly so capture can start in the middle of a scan.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sh1      <= 7'b0000000;
      r_sh2      <= 7'b0000000;
      r_sh3      <= 7'b0000000;
      r_scan_err <= 1'b0;
    end else begin
      r_scan_err <= 1'b0;
      if (!w_an_zero) begin
        if (!w_an_onehot) begin
          r_scan_err <= 1'b1;
          r_state    <= StIdle;
        end else if (an == 4'b1000) begin
          r_state <= StGot1;
          r_sh1   <= seg;
        end else begin
          case (r_state)
            StIdle: begin
              r_state <= StIdle;
            end
            StGot1: begin
              if (an == 4'b0100) begin
                r_state <= StGot2;
                r_sh2   <= seg;
              end else begin
                r_scan_err <= 1'b1;
                r_state    <= StIdle;
              end
            end
            StGot2: begin
              if (an == 4'b0010) begin
                r_state <= StGot3;
                r_sh3   <= seg;
              end else begin
                r_scan_err <= 1'b1;
                r_state    <= StIdle;
              end
            end
            StGot3: begin
              // 0001 completes the frame; DK4 is taken straight from seg.
              if (an != 4'b0001) begin
                r_scan_err <= 1'b1;
              end
              r_state <= StIdle;
            end
            default: begin
              r_state <= StIdle;
            end
          endcase
        end
      end
    end
  end

  // Frame delivery and handshake. A new frame wins over a same-cycle ack, and
  // overrun only records frames that overwrite one nobody acknowledged.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_dk1         <= 7'b0000000;
      r_dk2         <= 7'b0000000;
      r_dk3         <= 7'b0000000;
      r_dk4         <= 7'b0000000;
      r_code1       <= 4'hA;
      r_code2       <= 4'hA;
      r_code3       <= 4'hA;
      r_code4       <= 4'hA;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_deliver) begin
        r_dk1         <= r_sh1;
        r_dk2         <= r_sh2;
        r_dk3         <= r_sh3;
        r_dk4         <= seg;
        r_code1       <= decode_seg(r_sh1);
        r_code2       <= decode_seg(r_sh2);
        r_code3       <= decode_seg(r_sh3);
        r_code4       <= decode_seg(seg);
        r_frame_valid <= 1'b1;
        if (r_frame_valid && !frame_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (frame_ack) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  // Cycles since the last completed frame, saturating at the limit.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_stale_cnt <= '0;
    end else if (w_complete) begin
      r_stale_cnt <= '0;
    end else if (r_stale_cnt != StaleMax) begin
      r_stale_cnt <= r_stale_cnt + 1'b1;
    end
  end

  assign dk1         = r_dk1;
  assign dk2         = r_dk2;
  assign dk3         = r_dk3;
  assign dk4         = r_dk4;
  assign code1       = r_code1;
  assign code2       = r_code2;
  assign code3       = r_code3;
  assign code4       = r_code4;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;
  assign scan_err    = r_scan_err;
  assign stale       = (r_stale_cnt == StaleMax);

endmodule

// File: tb/tb_seg7_scan_capture.sv
`timescale 1ns / 1ps

module tb_seg7_scan_capture;

  localparam int unsigned Limit = 8;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] BL = 7'b0000000;
  localparam logic [6:0] PX = 7'b1110001;

  logic       clk_1khz = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = '0;
  logic [3:0] an = '0;
  logic       frame_ack = 1'b0;
  logic [6:0] dk1, dk2, dk3, dk4;
  logic [3:0] code1, code2, code3, code4;
  logic       frame_valid, overrun, scan_err, stale;

  seg7_scan_capture #(
    .STALE_LIMIT(Limit)
  ) dut (
    .clk_1khz   (clk_1khz),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .frame_ack  (frame_ack),
    .dk1        (dk1),
    .dk2        (dk2),
    .dk3        (dk3),
    .dk4        (dk4),
    .code1      (code1),
    .code2      (code2),
    .code3      (code3),
    .code4      (code4),
    .frame_valid(frame_valid),
    .overrun    (overrun),
    .scan_err   (scan_err),
    .stale      (stale)
  );

  always #5 clk_1khz = ~clk_1khz;

  typedef struct packed {
    logic       fv;
    logic       ov;
    logic       err;
    logic       stl;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [6:0] d3;
    logic [6:0] d4;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [3:0] c3;
    logic [3:0] c4;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  // Reference model: position within the scan (digits seen so far), captured
  // patterns, and the delivered frame as the consumer should see it.
  logic [6:0] digit_pat[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  int         m_pos;
  logic [6:0] m_sh[3];
  logic [6:0] m_dk[4];
  logic       m_fv, m_ov, m_err;
  int         m_since;

  function automatic logic [3:0] ref_code(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (p == digit_pat[i]) return 4'(i);
    end
    if (p == 7'b0000000) return 4'hA;
    return 4'hF;
  endfunction

  function automatic obs_t snapshot();
    obs_t o;
    o.fv  = m_fv;
    o.ov  = m_ov;
    o.err = m_err;
    o.stl = (m_since >= int'(Limit));
    o.d1  = m_dk[0];
    o.d2  = m_dk[1];
    o.d3  = m_dk[2];
    o.d4  = m_dk[3];
    o.c1  = ref_code(m_dk[0]);
    o.c2  = ref_code(m_dk[1]);
    o.c3  = ref_code(m_dk[2]);
    o.c4  = ref_code(m_dk[3]);
    return o;
  endfunction

  task automatic model_reset();
    m_pos   = 0;
    m_fv    = 1'b0;
    m_ov    = 1'b0;
    m_err   = 1'b0;
    m_since = 0;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
    for (int i = 0; i < 4; i++) m_dk[i] = '0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic ack);
    logic complete;
    logic deliver;
    int   k;
    complete = 1'b0;
    m_err    = 1'b0;
    if (a != 4'b0000) begin
      if ($countones(a) != 1) begin
        m_err = 1'b1;
        m_pos = 0;
      end else if (a == 4'b1000) begin
        m_pos   = 1;
        m_sh[0] = s;
      end else begin
        k = (a == 4'b0100) ? 2 : (a == 4'b0010) ? 3 : 4;
        if (m_pos != 0) begin
          if (k == m_pos + 1) begin
            if (k == 4) begin
              complete = 1'b1;
              m_pos    = 0;
            end else begin
              m_sh[k-1] = s;
              m_pos     = k;
            end
          end else begin
            m_err = 1'b1;
            m_pos = 0;
          end
        end
      end
    end
    deliver = complete;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
    if (complete && m_sh[0] == m_dk[0] && m_sh[1] == m_dk[1] && m_sh[2] == m_dk[2] &&
        s == m_dk[3]) begin
      deliver = 1'b0;
    end
`endif
    if (deliver) begin
      if (m_fv && !ack) m_ov = 1'b1;
      m_dk[0] = m_sh[0];
      m_dk[1] = m_sh[1];
      m_dk[2] = m_sh[2];
      m_dk[3] = s;
      m_fv    = 1'b1;
    end else if (ack) begin
      m_fv = 1'b0;
    end
    if (complete) m_since = 0;
    else if (m_since < int'(Limit)) m_since++;
  endtask

  // Driver: apply one cycle of inputs and queue the state expected after the
  // following rising edge.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic ack, input logic r);
    @(negedge clk_1khz);
    an        = a;
    seg       = s;
    frame_ack = ack;
    rst       = r;
    if (r) model_reset();
    else model_edge(a, s, ack);
    exp_q.push_back(snapshot());
  endtask

  task automatic scan(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3,
                      input logic [6:0] p4, input logic ack_last);
    step(4'b1000, p1, 1'b0, 1'b0);
    step(4'b0100, p2, 1'b0, 1'b0);
    step(4'b0010, p3, 1'b0, 1'b0);
    step(4'b0001, p4, ack_last, 1'b0);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(4'b0000, 7'b0000000, ack, 1'b0);
  endtask

  function automatic logic [6:0] rand_pat();
    if ($urandom_range(0, 3) != 0) return digit_pat[$urandom_range(0, 9)];
    return 7'($urandom);
  endfunction

  // Monitor: one observation per clock, sampled after the edge settles.
  obs_t mon_exp;
  obs_t mon_got;
  initial begin
    forever begin
      @(posedge clk_1khz);
      #2;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = '{frame_valid, overrun, scan_err, stale, dk1, dk2, dk3, dk4,
                    code1, code2, code3, code4};
        n_cmp++;
        n_cyc++;
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL cycle%0d: got fv=%b ov=%b err=%b stale=%b dk=%h/%h/%h/%h code=%h%h%h%h, expected fv=%b ov=%b err=%b stale=%b dk=%h/%h/%h/%h code=%h%h%h%h",
                   n_cyc, mon_got.fv, mon_got.ov, mon_got.err, mon_got.stl, mon_got.d1,
                   mon_got.d2, mon_got.d3, mon_got.d4, mon_got.c1, mon_got.c2, mon_got.c3,
                   mon_got.c4, mon_exp.fv, mon_exp.ov, mon_exp.err, mon_exp.stl, mon_exp.d1,
                   mon_exp.d2, mon_exp.d3, mon_exp.d4, mon_exp.c1, mon_exp.c2, mon_exp.c3,
                   mon_exp.c4);
        end
      end
    end
  end

  logic [3:0] r_an;
  int         sel;

  initial begin
    model_reset();
    step(4'b0000, BL, 1'b0, 1'b1);
    step(4'b0000, BL, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Basic frame " 120", then ack.
    scan(BL, P1, P2, P0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Mid-scan start: DK3/DK4 ignored in idle, then " 125".
    step(4'b0010, P5, 1'b0, 1'b0);
    step(4'b0001, P3, 1'b0, 1'b0);
    scan(BL, P1, P2, P5, 1'b0);
    idle(1, 1'b1);

    // Illegal enable during GOT2, then a normal scan.
    step(4'b1000, P1, 1'b0, 1'b0);
    step(4'b0100, P2, 1'b0, 1'b0);
    step(4'b0110, P3, 1'b0, 1'b0);
    idle(1, 1'b0);
    scan(P3, P2, P1, P0, 1'b0);
    idle(1, 1'b1);

    // Overrun, then ack coinciding with a completion.
    scan(P1, P1, P1, P1, 1'b0);
    scan(P2, P2, P2, P2, 1'b0);
    scan(P3, P3, P3, P3, 1'b1);
    idle(1, 1'b1);

    // Stale after the limit, cleared by the next frame.
    idle(Limit + 2, 1'b0);
    scan(P0, P1, P3, P0, 1'b0);
    idle(1, 1'b1);
    scan(P0, P1, P3, P0, 1'b0);
    idle(1, 1'b0);

    // Unknown pattern in DK1.
    scan(PX, P1, P3, P0, 1'b1);
    idle(1, 1'b0);

    // Reset mid-scan discards the partial frame.
    step(4'b1000, P1, 1'b0, 1'b0);
    step(4'b0100, P2, 1'b0, 1'b0);
    step(4'b0000, BL, 1'b0, 1'b1);
    step(4'b0010, P2, 1'b0, 1'b0);
    step(4'b0001, P3, 1'b0, 1'b0);
    scan(P5, P5, P0, P1, 1'b0);
    idle(1, 1'b1);

    // Randomised mix of clean scans and arbitrary enables.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        scan(rand_pat(), rand_pat(), rand_pat(), rand_pat(), 1'($urandom_range(0, 1)));
      end else begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: r_an = 4'b0000;
          1: r_an = 4'b1000;
          2: r_an = 4'b0100;
          3: r_an = 4'b0010;
          4: r_an = 4'b0001;
          default: r_an = 4'($urandom);
        endcase
        step(r_an, rand_pat(), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 99) == 0));
      end
    end
    idle(2, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_1khz);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d observations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
